packet_commit: RTL and testbench

//  Downstream of the UART packet demux. Stages one packet's payload bytes
//  (write_tick/addr/data) in a local buffer. Commits the packet to target

---
 rtl/packet_commit_pkg.sv | 9 +
 rtl/packet_stage_ram.sv | 18 +
 rtl/packet_commit.sv | 126 ++++++++++++
 tb/tb_packet_commit.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/packet_commit_pkg.sv
// packet_commit_pkg: FSM states, response byte defaults and address field widths for packet_commit.
package packet_commit_pkg;
  typedef enum logic [2:0] {IDLE, COLLECT, COMMIT, RESP, WAIT_TX} state_t;
  localparam int DEPTH_DEF = 256;
  localparam logic [7:0] ACK_DEF = 8'h06;
  localparam logic [7:0] NAK_DEF = 8'h15;
  localparam int PAGE_W = 8;
  localparam int OFF_W = 8;
endpackage

// File: rtl/packet_stage_ram.sv
// packet_stage_ram: DEPTH x 8 simple dual-port staging RAM, sync write, 1-cycle sync read.
module packet_stage_ram #(
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/packet_commit.sv
// packet_commit: stages a packet, commits it to memory on checksum success, answers ACK/NAK over UART TX.
// Optional packet statistics counters are built when PACKET_STATS_EN is defined.
module packet_commit
  import packet_commit_pkg::*;
#(
  parameter int         DEPTH    = DEPTH_DEF,
  parameter logic [7:0] ACK_BYTE = ACK_DEF,
  parameter logic [7:0] NAK_BYTE = NAK_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    write_tick,
  input  logic [7:0]              addr_in,
  input  logic [7:0]              data_in,
  input  logic                    success_tick,
  input  logic                    error_tick,
  input  logic                    tx_done_tick,
  output logic                    mem_we,
  output logic [PAGE_W+OFF_W-1:0] mem_addr,
  output logic [7:0]              mem_data,
  output logic                    tx_start,
  output logic [7:0]              tx_data,
  output logic                    busy,
  output logic [7:0]              ok_count,
  output logic [7:0]              err_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [8:0] FULL = 9'(DEPTH);
  state_t state, state_n;
  logic succ_q, err_q, succ_e, err_e, ack, resp_ack, enter_resp, ram_we, overflow;
  logic [7:0] page, rd_data;
  logic [8:0] wr_ptr, rd_ptr, len;
  assign succ_e = success_tick & ~succ_q;
  assign err_e = error_tick & ~err_q;
  assign resp_ack = (state == COMMIT);
  assign enter_resp = (state_n == RESP) && (state != RESP);
  assign ram_we = write_tick && ((state == IDLE) || (state == COLLECT && state_n == COLLECT && wr_ptr != FULL));
  assign tx_start = (state == RESP);
  assign tx_data = (state == RESP || state == WAIT_TX) ? (ack ? ACK_BYTE : NAK_BYTE) : 8'h00;
  assign busy = (state == COMMIT) || (state == RESP) || (state == WAIT_TX);
  assign mem_data = mem_we ? rd_data : 8'h00;
  packet_stage_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (state == IDLE ? AW'(0) : wr_ptr[AW-1:0]),
    .wdata (data_in),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_data)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  end
  // error wins over success; an overflowed packet can only be NAKed
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = write_tick ? COLLECT : (succ_e | err_e) ? RESP : IDLE;
      COLLECT: state_n = err_e ? RESP : succ_e ? (overflow ? RESP : COMMIT) : COLLECT;
      COMMIT:  state_n = (rd_ptr == len) ? RESP : COMMIT;
      RESP:    state_n = WAIT_TX;
      WAIT_TX: state_n = tx_done_tick ? IDLE : WAIT_TX;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      succ_q   <= 1'b0;
      err_q    <= 1'b0;
      ack      <= 1'b0;
      overflow <= 1'b0;
      page     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      len      <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
    end else begin
      succ_q <= success_tick;
      err_q  <= error_tick;
      mem_we <= 1'b0;
      if (enter_resp) ack <= resp_ack;
      case (state)
        IDLE: if (write_tick) begin
          page   <= addr_in;
          wr_ptr <= 9'd1;
        end
        COLLECT: begin
          if (write_tick && state_n == COLLECT) begin
            overflow <= overflow | (wr_ptr == FULL);
            wr_ptr   <= wr_ptr + 9'(wr_ptr != FULL);
          end
          if (state_n == COMMIT) begin
            len    <= wr_ptr;
            rd_ptr <= '0;
          end
        end
        COMMIT: if (rd_ptr != len) begin
          mem_we   <= 1'b1;
          mem_addr <= {page, rd_ptr[OFF_W-1:0]};
          rd_ptr   <= rd_ptr + 9'd1;
        end
        WAIT_TX: if (tx_done_tick) begin
          overflow <= 1'b0;
          wr_ptr   <= '0;
          rd_ptr   <= '0;
        end
        default: ;
      endcase
    end
  end
`ifdef PACKET_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ok_count  <= '0;
      err_count <= '0;
    end else if (enter_resp) begin
      ok_count  <= ok_count + 8'(resp_ack);
      err_count <= err_count + 8'(!resp_ack);
    end
  end
`else
  assign ok_count = '0;
  assign err_count = '0;
`endif
endmodule

// File: tb/tb_packet_commit.sv
// tb_packet_commit: table-driven packet vectors plus reset-mid-commit and stats wrap sequences.
module tb_packet_commit;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
`ifdef PACKET_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  typedef struct {
    logic [7:0] page;
    int         n;
    logic [7:0] base;
    int         kind;
    int         hold;
    int         exp_we;
    logic [7:0] exp_tx;
    bit         poke;
  } vec_t;
  logic clk = 1'b0, reset_n = 1'b0;
  logic write_tick = 1'b0, success_tick = 1'b0, error_tick = 1'b0, tx_done_tick = 1'b0;
  logic [7:0] addr_in = '0, data_in = '0;
  logic mem_we, tx_start, busy;
  logic [15:0] mem_addr;
  logic [7:0] mem_data, tx_data, ok_count, err_count;
  int checks = 0, failures = 0, tx_cnt = 0;
  logic [7:0] tx_byte = '0;
  logic [7:0] exp_ok = '0, exp_err = '0;
  logic [23:0] wq[$];
  vec_t tbl[9];
  packet_commit dut (
    .clk(clk), .reset_n(reset_n), .write_tick(write_tick), .addr_in(addr_in), .data_in(data_in),
    .success_tick(success_tick), .error_tick(error_tick), .tx_done_tick(tx_done_tick),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .tx_start(tx_start),
    .tx_data(tx_data), .busy(busy), .ok_count(ok_count), .err_count(err_count)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (mem_we) wq.push_back({mem_addr, mem_data});
    if (tx_start) begin
      tx_cnt = tx_cnt + 1;
      tx_byte = tx_data;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_stats();
    chk("ok_count", 32'(ok_count), 32'(STATS ? exp_ok : 8'h00));
    chk("err_count", 32'(err_count), 32'(STATS ? exp_err : 8'h00));
  endtask
  task automatic run_pkt(input vec_t v);
    int t, errs;
    wq.delete();
    tx_cnt = 0;
    for (int i = 0; i < v.n; i++) begin
      write_tick = 1'b1;
      addr_in = v.page;
      data_in = v.base + 8'(i);
      tick();
    end
    write_tick = 1'b0;
    addr_in = '0;
    success_tick = (v.kind != 1);
    error_tick = (v.kind != 0);
    repeat (v.hold) tick();
    success_tick = 1'b0;
    error_tick = 1'b0;
    t = 0;
    while (tx_cnt == 0 && t < 700) begin
      tick();
      t++;
    end
    chk("tx_seen", 32'(tx_cnt != 0), 32'd1);
    tick();
    tick();
    chk("busy_wait_tx", 32'(busy), 32'd1);
    chk("tx_data_held", 32'(tx_data), 32'(v.exp_tx));
    if (v.poke) begin
      write_tick = 1'b1;
      addr_in = 8'hEE;
      data_in = 8'hEE;
      tick();
      tick();
      write_tick = 1'b0;
      chk("busy_after_poke", 32'(busy), 32'd1);
    end
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
    tick();
    chk("idle_after_done", 32'(busy), 32'd0);
    chk("tx_count", 32'(tx_cnt), 32'd1);
    chk("tx_byte", 32'(tx_byte), 32'(v.exp_tx));
    chk("write_count", 32'(wq.size()), 32'(v.exp_we));
    errs = 0;
    foreach (wq[i]) if (wq[i] !== {v.page, 8'(i), v.base + 8'(i)}) errs++;
    if (v.exp_we > 0) chk("write_data", 32'(errs), 32'd0);
    if (v.exp_tx == ACK) exp_ok++;
    else exp_err++;
    chk_stats();
  endtask
  initial begin
    int t;
    tbl[0] = '{8'h12, 3,   8'hA0, 0, 5, 3,   ACK, 1'b0};
    tbl[1] = '{8'h34, 4,   8'hB0, 1, 1, 0,   NAK, 1'b0};
    tbl[2] = '{8'h56, 2,   8'hC0, 0, 1, 2,   ACK, 1'b0};
    tbl[3] = '{8'h78, 3,   8'hD0, 2, 1, 0,   NAK, 1'b1};
    tbl[4] = '{8'h40, 2,   8'h50, 0, 1, 2,   ACK, 1'b0};
    tbl[5] = '{8'h00, 0,   8'h00, 0, 1, 0,   NAK, 1'b0};
    tbl[6] = '{8'hFF, 257, 8'h00, 0, 1, 0,   NAK, 1'b0};
    tbl[7] = '{8'hAB, 256, 8'h00, 0, 1, 256, ACK, 1'b0};
    tbl[8] = '{8'h9A, 1,   8'h11, 1, 3, 0,   NAK, 1'b0};
    repeat (3) tick();
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_data", 32'(mem_data), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk_stats();
    reset_n = 1'b1;
    tick();
    foreach (tbl[i]) run_pkt(tbl[i]);
    wq.delete();
    tx_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      write_tick = 1'b1;
      addr_in = 8'h77;
      data_in = 8'h60 + 8'(i);
      tick();
    end
    write_tick = 1'b0;
    success_tick = 1'b1;
    tick();
    success_tick = 1'b0;
    t = 0;
    while (!(mem_we && mem_addr == 16'h7702) && t < 50) begin
      tick();
      t++;
    end
    chk("third_commit_byte", 32'(mem_we && mem_addr == 16'h7702), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_we_drop", 32'(mem_we), 32'd0);
    chk("async_busy_drop", 32'(busy), 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (20) tick();
    chk("rst_mid_writes", 32'(wq.size()), 32'd2);
    chk("rst_mid_no_tx", 32'(tx_cnt), 32'd0);
    chk("rst_mid_idle", 32'(busy), 32'd0);
    exp_ok = '0;
    exp_err = '0;
    chk_stats();
    for (int k = 0; k < 256; k++) run_pkt('{8'h01, 1, 8'h33, 0, 1, 1, ACK, 1'b0});
    chk("ok_wrap", 32'(ok_count), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
